// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-queue types and CPU constants used by the IF stage and its queue.
package if_fetch_queue_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic [4:0] {
    EXCEPT_ADEL = 5'd4
  } except_code_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } FetchEntry;

  typedef struct packed {
    logic [31:0] pc;
    logic        start_slot;
  } FetchTag;

  typedef enum logic [0:0] {
    StRun,
    StHalt
  } fq_state_e;

endpackage

// File: rtl/if_fq_fifo.sv
// Synchronous FetchEntry FIFO: up to WR_WIDTH writes and one read per cycle, wrap-bit pointers.
module if_fq_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WR_WIDTH = 2,
  localparam int unsigned PtrW    = $clog2(DEPTH) + 1,
  localparam int unsigned CntW    = $clog2(WR_WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [CntW-1:0]          wr_cnt,
  input  FetchEntry [WR_WIDTH-1:0] wr_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output FetchEntry                rd_data,
  output logic                     full,
  output logic [PtrW-1:0]          free_entries
);

  localparam int unsigned IdxW = PtrW - 1;

  logic [PtrW-1:0] wptr_q, rptr_q;
  FetchEntry       mem_q [DEPTH];

  assign rd_valid     = wptr_q != rptr_q;
  assign full         = (wptr_q[IdxW] != rptr_q[IdxW]) && (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]);
  assign free_entries = PtrW'(DEPTH) - (wptr_q - rptr_q);
  assign rd_data      = mem_q[rptr_q[IdxW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_q + PtrW'(wr_cnt);
      if (rd_en && rd_valid) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int i = 0; i < int'(WR_WIDTH); i++) begin
        if (i < int'(wr_cnt)) begin
          mem_q[wptr_q[IdxW-1:0] + IdxW'(i)] <= wr_data[i];
        end
      end
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Decoupled IF stage: fetch engine with pipelined I-bus requests feeding an instruction queue.
// Define IF_FQ_PERF_CNT_EN to add the saturating perf_* counter outputs.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH     = 2,
  parameter int unsigned FQ_DEPTH        = 8,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = if_fetch_queue_pkg::RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     ireq_valid,
  output logic [31:0]              ireq_addr,
  input  logic                     ireq_ready,
  input  logic                     iresp_valid,
  input  logic [32*FETCH_WIDTH-1:0] iresp_rdata,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [31:0]              deq_pc,
  output logic [31:0]              deq_instr,
  output logic                     deq_adel
`ifdef IF_FQ_PERF_CNT_EN
  ,
  output logic [31:0]              perf_fq_full_cycles,
  output logic [31:0]              perf_dropped_beats,
  output logic [31:0]              perf_empty_cycles
`endif
);

  localparam int unsigned BeatBytes = 4 * FETCH_WIDTH;
  localparam int unsigned FreeW     = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned CntW      = $clog2(FETCH_WIDTH + 1);
  localparam int unsigned TagW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [31:0] AlignMask = ~32'(BeatBytes - 1);

  function automatic logic [TagW-1:0] tag_inc(input logic [TagW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction

  fq_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  FetchTag     tag_q [MAX_OUTSTANDING];
  logic [TagW-1:0] tag_wr_q, tag_rd_q;

  logic        misaligned, space_ok, req_fire, resp_drop, resp_live, deq_fire;
  logic        head_valid, fifo_full;
  logic [FreeW-1:0] free_entries;
  logic [CntW-1:0]  wr_cnt;
  FetchEntry [FETCH_WIDTH-1:0] wr_data;
  FetchEntry   head;
  FetchTag     resp_tag;
  logic [31:0] resp_base;

  assign misaligned = fetch_pc_q[1:0] != 2'b00;
  // Reserve room for every beat in flight so responses never need back-pressure.
  assign space_ok   = 32'(free_entries) >= FETCH_WIDTH * (32'(outstanding_q) + 32'd1);
  assign ireq_valid = !rst && (state_q == StRun) && !redirect_valid && !misaligned &&
                      (32'(outstanding_q) < MAX_OUTSTANDING) && space_ok;
  assign ireq_addr  = fetch_pc_q & AlignMask;
  assign req_fire   = ireq_valid && ireq_ready;
  assign resp_drop  = iresp_valid && ((drop_cnt_q != 2'd0) || redirect_valid);
  assign resp_live  = iresp_valid && !resp_drop;
  assign resp_tag   = tag_q[tag_rd_q];
  assign resp_base  = resp_tag.pc & AlignMask;

  assign deq_valid = head_valid && !rst;
  assign deq_fire  = deq_valid && deq_ready;
  assign deq_pc    = head.pc;
  assign deq_instr = head.instr;
  assign deq_adel  = head.adel;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + {1'b0, req_fire} - {1'b0, iresp_valid};
    drop_cnt_d    = drop_cnt_q;
    wr_cnt        = '0;
    wr_data       = '0;

    if (resp_live) begin
      wr_cnt = CntW'(FETCH_WIDTH - 32'(resp_tag.start_slot));
      for (int j = 0; j < int'(FETCH_WIDTH); j++) begin
        if (j + int'(resp_tag.start_slot) < int'(FETCH_WIDTH)) begin
          wr_data[j].pc    = resp_base + 32'(4 * (j + int'(resp_tag.start_slot)));
          wr_data[j].instr = iresp_rdata[32 * (j + int'(resp_tag.start_slot)) +: 32];
          wr_data[j].adel  = 1'b0;
        end
      end
    end

    if (resp_drop && !redirect_valid) begin
      drop_cnt_d = drop_cnt_q - 2'd1;
    end

    if (req_fire) begin
      fetch_pc_d = (fetch_pc_q & AlignMask) + 32'(BeatBytes);
    end else if ((state_q == StRun) && misaligned && (outstanding_q == drop_cnt_q) &&
                 (!fifo_full || deq_fire)) begin
      // Only raise AdEL once every live beat ahead of it has landed, so it stays in order.
      wr_cnt        = CntW'(1);
      wr_data[0]    = '{pc: fetch_pc_q, instr: 32'd0, adel: 1'b1};
      state_d       = StHalt;
    end

    if (redirect_valid) begin
      state_d    = StRun;
      fetch_pc_d = redirect_pc;
      wr_cnt     = '0;
      drop_cnt_d = outstanding_q - {1'b0, iresp_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      if (req_fire) begin
        tag_wr_q <= tag_inc(tag_wr_q);
      end
      if (iresp_valid) begin
        tag_rd_q <= tag_inc(tag_rd_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_q[tag_wr_q] <= '{pc: fetch_pc_q,
                           start_slot: (FETCH_WIDTH == 2) ? fetch_pc_q[2] : 1'b0};
    end
  end

  if_fq_fifo #(
    .DEPTH    (FQ_DEPTH),
    .WR_WIDTH (FETCH_WIDTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush        (redirect_valid),
    .wr_cnt       (wr_cnt),
    .wr_data      (wr_data),
    .rd_en        (deq_fire),
    .rd_valid     (head_valid),
    .rd_data      (head),
    .full         (fifo_full),
    .free_entries (free_entries)
  );

`ifdef IF_FQ_PERF_CNT_EN
  logic [31:0] perf_full_q, perf_drop_q, perf_empty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_q  <= '0;
      perf_drop_q  <= '0;
      perf_empty_q <= '0;
    end else begin
      if (fifo_full && (perf_full_q != '1)) perf_full_q <= perf_full_q + 32'd1;
      if (resp_drop && (perf_drop_q != '1)) perf_drop_q <= perf_drop_q + 32'd1;
      if (!deq_valid && (perf_empty_q != '1)) perf_empty_q <= perf_empty_q + 32'd1;
    end
  end

  assign perf_fq_full_cycles = perf_full_q;
  assign perf_dropped_beats  = perf_drop_q;
  assign perf_empty_cycles   = perf_empty_q;
`endif

endmodule
